counter_prog: RTL
=================

// Module: counter_prog
// PURPOSE
//  Programmable, parametrised successor to our fixed 8-bit counter.
//  - Configurable width, prescaler, modulo limit and three counting modes: wrap, one-shot, ping-pong.
//  - Provides a terminal-count pulse and a compare output.
//  - Instantiated inside the TinyTapeout user-project top; the top maps ui_in/uio_in to controls and count to uo_out.
// PARAMETERS
//  WIDTH       8  counter / limit / compare width in bits
//  PRESCALE_W  8  prescaler reload width; step rate = clk/(prescale+1)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  ena        in   1           count enable; when 0, count and prescaler hold
//  load       in   1           synchronous load of load_val (overrides ena)
//  load_val   in   WIDTH       value written by load
//  dir        in   1           1=up, 0=down (wrap/one-shot modes only)
//  mode       in   2           00 wrap, 01 one-shot, 10 ping-pong, 11 = hold (no stepping)
//  max_val    in   WIDTH       modulo limit (inclusive upper bound)
//  cmp_val    in   WIDTH       compare value
//  prescale   in   PRESCALE_W  prescaler reload
//  count      out  WIDTH       registered counter value
//  tc         out  1           1-cycle terminal-count pulse, registered
//  cmp_match  out  1           (count == cmp_val), combinational from the count register
//  done       out  1           one-shot finished, level; cleared by load
// BEHAVIOUR
//  - Reset (async assert, sync release): count=0, tc=0, done=0, prescaler=0, ping-pong dir=up.
//  - Priority: rst > load > step.
//  - load: count<=load_val; prescaler<=0; done<=0; ping-pong dir<=up; tc<=0.
//  - tick: prescaler counts 0..prescale while ena=1. tick=1 in the cycle prescaler==prescale, then prescaler<=0.
//    prescale=0 gives a tick every enabled cycle.
//  - step = ena & tick & ~load & (mode!=11). All state changes land on the next clk edge (1-cycle latency).
//  - wrap, up:     count>=max_val -> 0 with tc=1; else count+1.
//  - wrap, down:   count==0 -> max_val with tc=1; else count-1. If count>max_val, it decrements normally.
//  - one-shot:     as wrap, but on reaching the endpoint (max_val up, 0 down) count stays there, tc=1 once, done<=1.
//                  While done=1, no further steps and no further tc. Up with count>max_val sets done immediately with no tc.
//  - ping-pong:    dir input ignored; internal dir_q.
//                  up: at max_val -> reverse, count-1, tc=1.
//                  down: at 0 -> reverse, count+1, tc=1.
//                  max_val=0 -> count stays 0, tc every step.
//  - tc is 0 in every cycle following a non-terminal step or no step.
//  - Mode, dir, max_val and cmp_val changes take effect on the next step. done and dir_q are preserved across mode changes.
//  - Arithmetic is modulo 2^WIDTH. No step ever produces a value outside [0, 2^WIDTH-1].
//  - rst asserted mid-count: outputs return to reset values immediately (async), regardless of clk.
// STRUCTURE
//  - counter_prog_pkg: mode localparams MODE_WRAP=2'b00, MODE_ONESHOT=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11.
//  - Sub-module counter_prescaler (PRESCALE_W): inputs clk, rst, ena, clr(=load), prescale; output tick.
//  - Top-level block: step decode, next-count mux, done/dir_q/tc registers, cmp comparator.
// TESTING
//  1. Wrap up, max=5, prescale=0, dir=1, ena=1 for 14 clk -> count 0,1,2,3,4,5,0,1,...; tc high exactly when 5->0 (2 pulses).
//  2. prescale=3, wrap up, max=255 -> count increments every 4th clk. ena=0 for 10 clk -> count and prescaler frozen.
//  3. One-shot down, load 3 -> count 3,2,1,0, then stays 0; tc once at 1->0; done=1. Next load 7 -> done=0, counting resumes.
//  4. Ping-pong, max=3, from reset -> 0,1,2,3,2,1,0,1; tc at 3->2 and at 0->1; dir input toggling has no effect.
//  5. cmp_val=4, wrap up, max=9 -> cmp_match high exactly while count==4.
//     load with ena=1 and tick=1 in the same cycle -> count=load_val, no step.
//  6. Assert rst between clk edges mid-count (count=0x2A) -> count=0, tc=0, done=0 immediately.
//     Wrap down from 0 with max=200 -> next value 200, tc=1.

Source files
------------

// File: rtl/counter_prog_pkg.sv
// Shared definitions for the programmable counter.
//   MODE_*    : encodings of the 2-bit mode input
//   pp_dir_e  : direction register state used by ping-pong mode
package counter_prog_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic {
    PpDown = 1'b0,
    PpUp   = 1'b1
  } pp_dir_e;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for counter_prog: divides the enabled clock by (prescale + 1).
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   ena      : advance enable; prescaler holds when low
//   clr      : synchronous clear (driven by the counter's load)
//   prescale : reload value; tick every (prescale + 1) enabled cycles
//   tick     : high in the enabled cycle where the prescaler reaches prescale
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  // >= rather than == so that lowering prescale mid-count ticks at once
  // instead of running the prescaler all the way round.
  assign tick = ena & (pre_q >= prescale);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (ena) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable counter with wrap, one-shot and ping-pong modes.
//   clk, rst   : clock (rising) and asynchronous active-high reset
//   ena        : count enable (count and prescaler hold when low)
//   load       : synchronous load of load_val, overrides stepping
//   dir        : 1 = up, 0 = down (wrap / one-shot only)
//   mode       : 00 wrap, 01 one-shot, 10 ping-pong, 11 hold
//   max_val    : inclusive upper limit
//   cmp_val    : compare value for cmp_match
//   prescale   : step rate = enabled clk / (prescale + 1)
//   count      : registered counter value
//   tc         : registered one-cycle terminal-count pulse
//   cmp_match  : count == cmp_val
//   done       : one-shot finished (level), cleared by load
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  cmp_match,
  output logic                  done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  pp_dir_e          dir_q, dir_d;

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] count_inc, count_dec;

  counter_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clr     (load),
    .prescale(prescale),
    .tick    (tick)
  );

  assign step      = ena & tick & ~load & (mode != MODE_HOLD);
  assign count_inc = count_q + 1'b1;
  assign count_dec = count_q - 1'b1;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    dir_d   = dir_q;
    if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
      dir_d   = PpUp;
    end else if (step) begin
      unique case (mode)
        MODE_WRAP: begin
          if (dir) begin
            if (count_q >= max_val) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_inc;
            end
          end else begin
            if (count_q == '0) begin
              count_d = max_val;
              tc_d    = 1'b1;
            end else begin
              count_d = count_dec;
            end
          end
        end
        MODE_ONESHOT: begin
          if (!done_q) begin
            if (dir) begin
              // Already past the limit: finish silently without moving.
              if (count_q > max_val) begin
                done_d = 1'b1;
              end else if (count_q == max_val || count_inc == max_val) begin
                count_d = max_val;
                tc_d    = 1'b1;
                done_d  = 1'b1;
              end else begin
                count_d = count_inc;
              end
            end else begin
              if (count_q <= WIDTH'(1)) begin
                count_d = '0;
                tc_d    = 1'b1;
                done_d  = 1'b1;
              end else begin
                count_d = count_dec;
              end
            end
          end
        end
        MODE_PINGPONG: begin
          if (max_val == '0) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else if (dir_q == PpUp) begin
            if (count_q >= max_val) begin
              count_d = count_dec;
              dir_d   = PpDown;
              tc_d    = 1'b1;
            end else begin
              count_d = count_inc;
            end
          end else begin
            if (count_q == '0) begin
              count_d = count_inc;
              dir_d   = PpUp;
              tc_d    = 1'b1;
            end else begin
              count_d = count_dec;
            end
          end
        end
        MODE_HOLD: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= PpUp;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign done      = done_q;
  assign cmp_match = (count_q == cmp_val);

endmodule
